// File: rtl/pipe_if_stage_pkg.sv
// Pipeline-wide definitions shared by fetch and decode: PC source encoding,
// the bubble instruction, and the fetch-stage state encoding.
package pipe_if_stage_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  // sll r0,r0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [0:0] {
    StFetch = 1'b0,
    StHold  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/mux4x32.sv
// 4:1 multiplexer for 32-bit words, indexed by a 2-bit select.
module mux4x32 (
  input  logic [31:0] d0_i,
  input  logic [31:0] d1_i,
  input  logic [31:0] d2_i,
  input  logic [31:0] d3_i,
  input  logic [1:0]  sel_i,
  output logic [31:0] y_o
);

  always_comb begin
    y_o = d0_i;
    unique case (sel_i)
      2'b00: y_o = d0_i;
      2'b01: y_o = d1_i;
      2'b10: y_o = d2_i;
      2'b11: y_o = d3_i;
    endcase
  end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction fetch with IF/ID register: req/ready instruction memory, NOP bubbles
// while waiting, delayed-branch redirects remembered across wait states.
module pipe_if_stage
  import pipe_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = pipe_if_stage_pkg::NOP_INST
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  dpc4_q, dpc4_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_pc_q, pend_pc_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic [31:0] word;
  logic        in_fetch;
  logic        redirect;
  logic        deliver;

  assign pc_plus4 = pc_q + 32'd4;

  mux4x32 u_next_pc_mux (
    .d0_i  (pc_plus4),
    .d1_i  (bpc),
    .d2_i  (rpc),
    .d3_i  (jpc),
    .sel_i (pcsource),
    .y_o   (target)
  );

  always_comb begin
    in_fetch = (state_q == StFetch);
    redirect = (pcsource != PCSRC_SEQ);
    deliver  = wpcir & ((in_fetch & imem_ready) | ~in_fetch);
    word     = in_fetch ? imem_rdata : hold_inst_q;
    // A live redirect from decode beats a remembered one.
    next_pc  = redirect ? target : (pend_q ? pend_pc_q : pc_plus4);

    state_d     = state_q;
    pc_d        = pc_q;
    dpc4_d      = dpc4_q;
    inst_d      = inst_q;
    hold_inst_d = hold_inst_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;

    if (deliver) begin
      dpc4_d  = pc_plus4;
      inst_d  = word;
      pc_d    = next_pc;
      pend_d  = 1'b0;
      state_d = StFetch;
    end else if (wpcir) begin
      // Decode advances but fetch is still waiting: bubble, and keep any redirect.
      inst_d = NOP_INST;
      if (redirect) begin
        pend_d    = 1'b1;
        pend_pc_d = target;
      end
    end else if (in_fetch && imem_ready) begin
      hold_inst_d = imem_rdata;
      state_d     = StHold;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      dpc4_q      <= 32'h0000_0000;
      inst_q      <= NOP_INST;
      hold_inst_q <= 32'h0000_0000;
      pend_q      <= 1'b0;
      pend_pc_q   <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dpc4_q      <= dpc4_d;
      inst_q      <= inst_d;
      hold_inst_q <= hold_inst_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
    end
  end

  // Gated by resetn so an in-flight request is dropped the moment reset asserts.
  assign imem_req  = resetn & (state_q == StFetch);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign dpc4      = dpc4_q;
  assign inst      = inst_q;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Directed bench for pipe_if_stage: per-cycle expectations queued on drive, checked after the edge.
module tb_pipe_if_stage;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        wpcir;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc, dpc4, inst;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] dpc4;
    logic        req;
  } exp_t;

  exp_t sb[$];

  pipe_if_stage dut (
    .clock      (clock),
    .resetn     (resetn),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .wpcir      (wpcir),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .pc         (pc),
    .dpc4       (dpc4),
    .inst       (inst)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h8C00_0001;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected post-edge state, then compare.
  task automatic tick(input string tag, input logic rdy, input logic w, input logic [1:0] src,
                      input logic [31:0] tgt, input logic [31:0] e_addr,
                      input logic [31:0] e_inst, input logic [31:0] e_dpc4, input logic e_req);
    exp_t e;
    pcsource   = src;
    bpc        = (src == 2'b01) ? tgt : 32'h0BAD_0B00;
    rpc        = (src == 2'b10) ? tgt : 32'h0BAD_0A00;
    jpc        = (src == 2'b11) ? tgt : 32'h0BAD_0900;
    wpcir      = w;
    imem_ready = rdy;
    imem_rdata = rdy ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    sb.push_back('{tag: tag, addr: e_addr, inst: e_inst, dpc4: e_dpc4, req: e_req});
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq({e.tag, ".addr"}, imem_addr, e.addr);
      check_eq({e.tag, ".inst"}, inst, e.inst);
      check_eq({e.tag, ".dpc4"}, dpc4, e.dpc4);
      check_eq({e.tag, ".req"}, {31'd0, imem_req}, {31'd0, e.req});
    end
  endtask

  initial begin
    resetn     = 1'b0;
    pcsource   = 2'b00;
    bpc        = '0;
    rpc        = '0;
    jpc        = '0;
    wpcir      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = '0;

    #12;
    check_eq("rst.pc", pc, 32'h0);
    check_eq("rst.inst", inst, 32'h0);
    check_eq("rst.dpc4", dpc4, 32'h0);
    check_eq("rst.req", {31'd0, imem_req}, 32'd0);
    resetn = 1'b1;
    #1;
    check_eq("start.req", {31'd0, imem_req}, 32'd1);
    check_eq("start.addr", imem_addr, 32'h0);

    // Zero-wait sequential fetch
    for (int k = 1; k <= 5; k++) begin
      tick("seq", 1'b1, 1'b1, 2'b00, 32'h0, 32'(4 * k), mem_word(32'(4 * (k - 1))),
           32'(4 * k), 1'b1);
    end
    // Branch at 0x10 in decode: slot 0x14 delivered, then 0x40
    tick("br.slot", 1'b1, 1'b1, 2'b01, 32'h40, 32'h40, mem_word(32'h14), 32'h18, 1'b1);
    tick("br.tgt", 1'b1, 1'b1, 2'b00, 32'h0, 32'h44, mem_word(32'h40), 32'h44, 1'b1);

    // Jump in decode while the slot fetch at 0x44 waits 3 cycles
    tick("j.wait1", 1'b0, 1'b1, 2'b11, 32'h100, 32'h44, 32'h0, 32'h44, 1'b1);
    tick("j.wait2", 1'b0, 1'b1, 2'b00, 32'h0, 32'h44, 32'h0, 32'h44, 1'b1);
    tick("j.wait3", 1'b0, 1'b1, 2'b00, 32'h0, 32'h44, 32'h0, 32'h44, 1'b1);
    tick("j.slot", 1'b1, 1'b1, 2'b00, 32'h0, 32'h100, mem_word(32'h44), 32'h48, 1'b1);
    tick("j.tgt", 1'b1, 1'b1, 2'b00, 32'h0, 32'h104, mem_word(32'h100), 32'h104, 1'b1);

    // Ready while stalled -> HOLD; pcsource ignored while wpcir=0
    tick("hold1", 1'b1, 1'b0, 2'b00, 32'h0, 32'h104, mem_word(32'h100), 32'h104, 1'b0);
    tick("hold2", 1'b0, 1'b0, 2'b11, 32'h999, 32'h104, mem_word(32'h100), 32'h104, 1'b0);
    tick("hold.rel", 1'b0, 1'b1, 2'b00, 32'h0, 32'h108, mem_word(32'h104), 32'h108, 1'b1);

    // Jump to the top of memory, then sequential wrap
    tick("wrap.j", 1'b1, 1'b1, 2'b11, 32'hFFFF_FFF8, 32'hFFFF_FFF8, mem_word(32'h108),
         32'h10C, 1'b1);
    tick("wrap.a", 1'b1, 1'b1, 2'b00, 32'h0, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFF8),
         32'hFFFF_FFFC, 1'b1);
    tick("wrap.b", 1'b1, 1'b1, 2'b00, 32'h0, 32'h0, mem_word(32'hFFFF_FFFC), 32'h0, 1'b1);

    // Jump-register redirect with zero wait
    tick("jr", 1'b1, 1'b1, 2'b10, 32'h200, 32'h200, mem_word(32'h0), 32'h4, 1'b1);
    tick("jr.tgt", 1'b1, 1'b1, 2'b00, 32'h0, 32'h204, mem_word(32'h200), 32'h204, 1'b1);

    // Reset mid-wait at pc=0x24
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    #1;
    for (int k = 1; k <= 9; k++) begin
      tick("seq2", 1'b1, 1'b1, 2'b00, 32'h0, 32'(4 * k), mem_word(32'(4 * (k - 1))),
           32'(4 * k), 1'b1);
    end
    tick("rst.wait", 1'b0, 1'b1, 2'b00, 32'h0, 32'h24, 32'h0, 32'h24, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("midrst.pc", pc, 32'h0);
    check_eq("midrst.inst", inst, 32'h0);
    check_eq("midrst.dpc4", dpc4, 32'h0);
    check_eq("midrst.req", {31'd0, imem_req}, 32'd0);
    #2;
    resetn = 1'b1;
    #1;
    check_eq("restart.req", {31'd0, imem_req}, 32'd1);
    tick("restart", 1'b1, 1'b1, 2'b00, 32'h0, 32'h4, mem_word(32'h0), 32'h4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
